// File: rtl/data_mem_responder.sv
// Wait-state data-memory responder: accepts a core read/write, stalls WAIT_CYCLES, then acks.
// Optional build macro MEM_ALIGN_CHECK_EN adds mem_err and blocks misaligned accesses.
module data_mem_responder #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_ren,
   input  logic        mem_wen,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_din,
   input  logic [3:0]  mem_wmask,
   output logic [31:0] mem_dout,
   output logic        mem_ack,
`ifdef MEM_ALIGN_CHECK_EN
   output logic        mem_busy,
   output logic        mem_err
`else
   output logic        mem_busy
`endif
);

   localparam int unsigned Depth = 1 << ADDR_WIDTH;
   localparam logic [3:0] CntInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StWait, StAck} state_t;

   state_t                state;
   logic [3:0]            wait_cnt;
   logic [ADDR_WIDTH-1:0] req_idx;
   logic [31:0]           req_din;
   logic [3:0]            req_wmask;
   logic                  req_write;
   logic                  req_misalign;

   logic [31:0] mem [Depth];

   logic                  req_valid;
   logic                  enter_ack;
   logic [ADDR_WIDTH-1:0] cur_idx;
   logic [31:0]           cur_din;
   logic [3:0]            cur_wmask;
   logic                  cur_write;
   logic                  cur_misalign;
   logic                  cur_ok;
   logic                  commit_wr;
   logic                  commit_rd;
   logic                  unused_addr;

   assign req_valid   = mem_ren | mem_wen;
   assign unused_addr = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};

   // With zero wait states the edge entering ACK is the accepting edge, so the
   // access uses the live inputs instead of the (not yet latched) request.
   always_comb begin
      enter_ack    = 1'b0;
      cur_idx      = req_idx;
      cur_din      = req_din;
      cur_wmask    = req_wmask;
      cur_write    = req_write;
      cur_misalign = req_misalign;
      case (state)
         StIdle: begin
            enter_ack    = req_valid && (WAIT_CYCLES == 0);
            cur_idx      = mem_addr[ADDR_WIDTH+1:2];
            cur_din      = mem_din;
            cur_wmask    = mem_wmask;
            cur_write    = mem_wen;
            cur_misalign = (mem_addr[1:0] != 2'b00);
         end
         StWait:  enter_ack = (wait_cnt == '0);
         default: enter_ack = 1'b0;
      endcase
   end

`ifdef MEM_ALIGN_CHECK_EN
   assign cur_ok = ~cur_misalign;
`else
   assign cur_ok = 1'b1;
`endif

   // rst_n gate keeps a request held during reset from reaching the array.
   assign commit_wr = enter_ack && cur_write && cur_ok && rst_n;
   assign commit_rd = enter_ack && !cur_write && cur_ok;

   always_ff @(posedge clk) begin
      if (commit_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (cur_wmask[b]) mem[cur_idx][8*b +: 8] <= cur_din[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= StIdle;
         wait_cnt     <= '0;
         req_idx      <= '0;
         req_din      <= '0;
         req_wmask    <= '0;
         req_write    <= 1'b0;
         req_misalign <= 1'b0;
         mem_dout     <= '0;
         mem_ack      <= 1'b0;
         mem_busy     <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
         mem_err      <= 1'b0;
`endif
      end else begin
         mem_ack <= enter_ack;
`ifdef MEM_ALIGN_CHECK_EN
         mem_err <= enter_ack && cur_misalign;
`endif
         if (commit_rd) mem_dout <= mem[cur_idx];
         case (state)
            StIdle: begin
               if (req_valid) begin
                  req_idx      <= mem_addr[ADDR_WIDTH+1:2];
                  req_din      <= mem_din;
                  req_wmask    <= mem_wmask;
                  req_write    <= mem_wen;
                  req_misalign <= (mem_addr[1:0] != 2'b00);
                  mem_busy     <= 1'b1;
                  if (WAIT_CYCLES == 0) begin
                     state <= StAck;
                  end else begin
                     state    <= StWait;
                     wait_cnt <= CntInit;
                  end
               end
            end
            StWait: begin
               if (wait_cnt == '0) state <= StAck;
               else wait_cnt <= wait_cnt - 4'd1;
            end
            StAck: begin
               state    <= StIdle;
               mem_busy <= 1'b0;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the core's data-memory port: accepts read/write requests from `mips_core`, applies a programmable number of wait states, then completes them with a one-cycle acknowledge.
- Sits between the core's `mem_*` signals and an internal word-organised storage array.
- Replaces the zero-latency `data_ram`, so the core's stall and handshake logic can be exercised against realistic memory latency.

Parameters:
- ADDR_WIDTH, 10, word-address bits; array depth is 2^ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2, wait states between request acceptance and ack; legal range 0..15.

Ports:
- clk  input  1  main clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mem_ren  input  1  read request.
- mem_wen  input  1  write request.
- mem_addr  input  32  byte address; word index is mem_addr[ADDR_WIDTH+1:2].
- mem_din  input  32  write data from the core.
- mem_wmask  input  4  byte write enables; bit i covers mem_din[8i+7:8i].
- mem_dout  output  32  read data to the core.
- mem_ack  output  1  one-cycle completion pulse.
- mem_busy  output  1  request in flight; new requests are ignored while high.

Behaviour:
- Reset, interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset, state: while rst_n is low, FSM=IDLE, mem_dout=0, mem_ack=0, mem_busy=0, wait counter=0, latched request cleared.
- Reset, storage: array contents are not reset; a read before any write returns X.
- Reset mid-operation: aborts the transaction; a pending write is not committed; no ack is issued.
- FSM has three states: IDLE, WAIT, ACK.
- IDLE:
  - At a rising edge with mem_ren|mem_wen=1, latch addr, din, wmask and op.
  - If WAIT_CYCLES=0, go to ACK; otherwise go to WAIT with counter=WAIT_CYCLES-1.
  - mem_busy=1 from the next cycle.
- WAIT: counter decrements each cycle; when it reaches 0, go to ACK at the next edge.
- ACK:
  - mem_ack=1 for exactly one cycle; next state is IDLE.
  - Requests present during the ACK cycle are ignored.
- Timing: a request accepted at edge T gives mem_ack high in cycle T+1+WAIT_CYCLES.
- Minimum request-to-request spacing is WAIT_CYCLES+2 cycles.
- mem_busy is high from cycle T+1 through the ack cycle inclusive; low in IDLE.
- Write commit:
  - The array is updated at the edge entering ACK, only for bytes with wmask=1.
  - wmask=0000 still completes with an ack and leaves memory unchanged.
- Read:
  - mem_dout is registered at the edge entering ACK, so it is valid in the ack cycle.
  - It holds that value until the next completed read or reset; writes never change mem_dout.
- Simultaneous mem_ren and mem_wen in IDLE: treated as a write only; mem_dout is unchanged.
- Addressing:
  - mem_addr bits above ADDR_WIDTH+1 are ignored, so addresses alias modulo the array size.
  - mem_addr[1:0] is ignored unless the optional feature below is compiled in.
- Request inputs are sampled only in IDLE; the core must hold them until it sees ack.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- When defined:
  - Adds output port mem_err (1 bit, reset 0).
  - A request with latched mem_addr[1:0]!=2'b00 still follows normal FSM timing.
  - No array write occurs, mem_dout is unchanged, and mem_err=1 in the ack cycle only; otherwise mem_err=0.
- When undefined: no mem_err port; mem_addr[1:0] is ignored and every request accesses the word at mem_addr[ADDR_WIDTH+1:2].

Test Plan:
1. Reset: hold rst_n=0 at any time, including with requests asserted -> mem_ack=0, mem_busy=0, mem_dout=0 immediately (asynchronous).
2. Latency, write then read (WAIT_CYCLES=2): write 0xDEADBEEF to 0x10, wmask=4'hF, accepted at edge T -> mem_busy high T+1..T+3, mem_ack high only in T+3. Then read 0x10 -> mem_ack three cycles after acceptance with mem_dout=0xDEADBEEF.
3. Byte mask and priority:
   - Write 0x000000AA to 0x10 with wmask=4'b0001 -> read returns 0xDEADBEAA.
   - ren=wen=1 writing 0x11111111 to 0x14 -> mem_dout keeps its prior value; a later read of 0x14 returns 0x11111111.
4. Busy ignore and aliasing (ADDR_WIDTH=10):
   - Read 0x1010 -> returns the contents of 0x0010.
   - A write to 0x20 issued during WAIT of another request -> never acked, memory at 0x20 unchanged.
5. Reset mid-write: write 0x12345678 to 0x10, assert rst_n=0 in WAIT, release, read 0x10 -> old value returned, no stray ack.
6. Zero latency and alignment:
   - WAIT_CYCLES=0 -> ack in cycle T+1.
   - With MEM_ALIGN_CHECK_EN defined, write to 0x13 -> mem_err=1 with ack; memory at 0x10 unchanged.
